datamem_seq: RTL and testbench
==============================

DATAMEM_SEQ -- requirements
Module: datamem_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter WORD_ADDR_W, default 10, RAM word-address width (2^WORD_ADDR_W words).
REQ-003 SHALL have one clock and an asynchronous active-high reset: port clk (input, 1, rising-edge clock) and port rst (input, 1, asynchronous, active-high).
REQ-004 SHALL have req_valid (input, 1): access request from the pipeline.
REQ-005 SHALL have req_ready (output, 1): request accepted on a cycle where req_valid && req_ready.
REQ-006 SHALL have req_addr (input, 32): byte address.
REQ-007 SHALL have req_we (input, 1): 1 for store, 0 for load.
REQ-008 SHALL have req_size (input, 3): 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 SHALL have req_wdata (input, DATA_WIDTH): full store word.
REQ-010 SHALL have rd_word (output, DATA_WIDTH): raw RAM word to the lane-formatting stage.
REQ-011 SHALL have wr_word (input, DATA_WIDTH): merged store word from the lane-formatting stage.
REQ-012 SHALL have offset (output, 2): latched addr[1:0] to the lane stage.
REQ-013 SHALL have size_q (output, 3): latched size to the lane stage.
REQ-014 SHALL have rsp_valid (output, 1): one-cycle completion pulse.
REQ-015 SHALL have rsp_err (output, 1): qualifies rsp_valid; the access was rejected.
REQ-016 SHALL have busy (output, 1): pipeline stall, high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, READ, MERGE, WRITE, RESP; req_ready = (state == IDLE).
REQ-018 SHALL latch addr, size, we, and wdata on acceptance (cycle T); later input changes SHALL be ignored until the next IDLE.
REQ-019 SHALL, for a load, go IDLE->READ (T+1, RAM address driven) ->RESP (T+2: rd_word = RAM data, rsp_valid=1) ->IDLE.
REQ-020 SHALL, for a word store, go IDLE->WRITE (T+1: RAM written with latched wdata, rsp_valid=1) ->IDLE.
REQ-021 SHALL, for a byte or halfword store, go IDLE->READ (T+1) ->MERGE (T+2: rd_word valid, RAM written with wr_word on the closing edge, rsp_valid=1) ->IDLE.
REQ-022 SHALL hold rd_word stable from RAM data arrival until the next acceptance.
REQ-023 SHALL address the RAM with latched addr[WORD_ADDR_W+1:2]; higher address bits are ignored, so the address wraps modulo the RAM size.
REQ-024 SHALL treat an invalid size (011, 110, 111) or a store with size bu/hu as follows: IDLE->RESP at T+1 with rsp_err=1, no RAM write, rd_word unchanged.
REQ-025 SHALL keep req_ready low for the whole access; a request presented while busy is not accepted, and the requester holds it.
REQ-026 SHALL make a new acceptance possible in the cycle after rsp_valid; back-to-back throughput is 1 access per 2 or 3 cycles.

Reset
REQ-027 SHALL, on rst, immediately set state to IDLE, with rsp_valid=0, rsp_err=0, busy=0, req_ready=1, rd_word=0, offset=0, size_q=0.
REQ-028 SHALL ensure that reset during READ or MERGE suppresses the pending RAM write; RAM contents are not reset.

Configuration
REQ-029 SHALL, with MISALIGN_TRAP_EN defined, complete misaligned accesses (h/hu with addr[0]=1, w with addr[1:0]!=0) per REQ-024, with rsp_err=1 and no write.
REQ-030 SHALL, without MISALIGN_TRAP_EN, force the low address bits to alignment (h: addr[0]=0, w: addr[1:0]=00) at latch time and process the access normally.

Structure
REQ-031 SHALL place the size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the state enum in the package datamem_pkg.
REQ-032 SHALL place RAM storage in the sub-module data_ram: synchronous single-port, 1-cycle read, write-enable, no reset.

Verification
REQ-033 SHALL cover: sw addr 0x10 data 0xDEADBEEF -> rsp_valid at T+1, err=0; then lw 0x10 -> rsp_valid at T+2, rd_word=0xDEADBEEF.
REQ-034 SHALL cover: sb addr 0x11 with bench lane model -> busy for 2 cycles, rd_word=0xDEADBEEF at T+2, offset=01; a later lw reads 0xDEAD55EF after wdata 0x55.
REQ-035 SHALL cover: lh addr 0x13 -> with MISALIGN_TRAP_EN, rsp_err=1 at T+1 and no write; without it, offset=10 and rsp_valid at T+2.
REQ-036 SHALL cover: size 011 -> rsp_err=1 at T+1 and memory unchanged; sb at 0x10 then immediate req held -> second accept exactly one cycle after the first rsp_valid.
REQ-037 SHALL cover: rst asserted mid-MERGE of sh 0x12 -> outputs reset at once, and a later lw 0x10 returns the pre-store word.
REQ-038 SHALL cover: sw to byte address 0x1010 with WORD_ADDR_W=10 -> lw 0x10 returns that data (wrap).

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared encodings for the data-memory sequencer, plus request-decoding helpers.
// The package has no timing and no flow control. It holds the access sizes, the FSM states and the legality/alignment rules.
package datamem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP
  } state_t;

  // Unsigned sizes only make sense for loads.
  function automatic logic size_legal(input logic [2:0] sz, input logic we);
    case (sz)
      SZ_B, SZ_H, SZ_W: return 1'b1;
      SZ_BU, SZ_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      SZ_H, SZ_HU: return off[0];
      SZ_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      SZ_H, SZ_HU: return {off[1], 1'b0};
      SZ_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Synchronous single-port RAM with a 1-cycle registered read. On a simultaneous write, the read returns the old word.
// The RAM has no reset and no backpressure: the sequencer owns every access.
module data_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/datamem_seq.sv
// Data-memory sequencer. Latency: load 2 cycles, word store 1 cycle, sub-word store 2 cycles (read then merge-write), rejected access 1 cycle.
// req_ready is low for the whole access. With MISALIGN_TRAP_EN defined, misaligned accesses are rejected instead of being aligned.
module datamem_seq
  import datamem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wr_word,
  output logic [1:0]            offset,
  output logic [2:0]            size_q,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int AW = WORD_ADDR_W + 2;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [2:0]            size_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic                  fresh_q;
  logic                  req_bad;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW];

  always_comb begin
    req_bad = !size_legal(req_size, req_we);
`ifdef MISALIGN_TRAP_EN
    req_bad = req_bad || misaligned(req_size, req_addr[1:0]);
`else
    req_bad = req_bad || 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
          addr_d = req_addr[AW-1:0];
`else
          addr_d = {req_addr[AW-1:2], align_off(req_size, req_addr[1:0])};
`endif
          size_d  = req_size;
          we_d    = req_we;
          wdata_d = req_wdata;
          err_d   = req_bad;
          if (req_bad)                      state_d = RESP;
          else if (req_we && req_size == SZ_W) state_d = WRITE;
          else                              state_d = READ;
        end
      end
      READ:    state_d = we_q ? MERGE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      fresh_q   <= 1'b0;
      rd_word_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      fresh_q <= (state_q == READ);
      if (fresh_q) rd_word_q <= ram_rdata;
    end
  end

  // Reset gates the write combinationally, so an edge that coincides with reset cannot commit a merge.
  assign ram_we    = !rst && (state_q == WRITE || state_q == MERGE);
  assign ram_wdata = (state_q == MERGE) ? wr_word : wdata_q;

  data_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (WORD_ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (addr_q[AW-1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign rd_word   = fresh_q ? ram_rdata : rd_word_q;
  assign offset    = addr_q[1:0];
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) || (state_q == WRITE) || (state_q == MERGE);
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_datamem_seq.sv
// Self-checking bench for datamem_seq: directed scenarios followed by randomized accesses.
// Results are compared against a word-array memory model and a lane merge model.
module tb_datamem_seq;

  localparam int DW  = 32;
  localparam int WAW = 10;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rd_word, wr_word;
  logic [1:0]  offset;
  logic [2:0]  size_q;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [int];
  logic [31:0] last_rd = '0;
  logic [31:0] st_data = '0;
  int          pool [8];

  datamem_seq #(.DATA_WIDTH(DW), .WORD_ADDR_W(WAW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .rd_word  (rd_word),
    .wr_word  (wr_word),
    .offset   (offset),
    .size_q   (size_q),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    if (sz == 3'b000)      r[int'(off) * 8 +: 8] = d[7:0];
    else if (sz == 3'b001) r[int'(off[1]) * 16 +: 16] = d[15:0];
    else                   r = d;
    return r;
  endfunction

  // External lane stage: merges the store data into the raw word.
  always_comb wr_word = merge(rd_word, offset, size_q, st_data);

  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'(1 << (WAW + 2))) / 32'd4);
  endfunction

  function automatic logic bad_req(input logic we, input logic [2:0] sz, input logic [31:0] a);
    logic bad, mis;
    bad = (sz == 3'b011) || (sz >= 3'b110) || (we && (sz == 3'b100 || sz == 3'b101));
    mis = ((sz == 3'b001 || sz == 3'b101) && (a % 2) != 0) || (sz == 3'b010 && (a % 4) != 0);
    return bad || (TRAP && mis);
  endfunction

  function automatic logic [31:0] eff_addr(input logic [2:0] sz, input logic [31:0] a);
    if (TRAP) return a;
    if (sz == 3'b001 || sz == 3'b101) return a - (a % 2);
    if (sz == 3'b010) return a - (a % 4);
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 6);
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    logic        bad;
    logic [31:0] ea, old;
    int          w, lat, n;
    bad = bad_req(we, sz, a);
    ea  = eff_addr(sz, a);
    w   = widx(ea);
    old = model.exists(w) ? model[w] : 32'hx;
    if (bad)                     lat = 1;
    else if (we && sz == 3'b010) lat = 1;
    else                         lat = 2;
    @(negedge clk);
    check({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = d; st_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    wait_rsp(n);
    check({tag, ":latency"}, 32'(n), 32'(lat));
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":err"}, 32'(rsp_err), 32'(bad));
    if (bad) begin
      check({tag, ":rd_kept"}, rd_word, last_rd);
    end else begin
      check({tag, ":offset"}, 32'(offset), ea % 4);
      check({tag, ":size_q"}, 32'(size_q), 32'(sz));
      if (!we || sz != 3'b010) begin
        check({tag, ":rd_word"}, rd_word, old);
        last_rd = old;
      end
      if (we) model[w] = merge(old, 2'(ea % 4), sz, d);
    end
    @(negedge clk);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    check({tag, ":rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_err", 32'(rsp_err), 32'd0);
    check("rst:rd_word", rd_word, 32'd0);
    check("rst:offset", 32'(offset), 32'd0);
    check("rst:size_q", 32'(size_q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    access("lw10", 1'b0, 3'b010, 32'h10, 32'h0);
    access("sb11", 1'b1, 3'b000, 32'h11, 32'h55);
    access("lw10b", 1'b0, 3'b010, 32'h10, 32'h0);
    access("lh13", 1'b0, 3'b001, 32'h13, 32'h0);
    access("sz011", 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
    access("sbu", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    access("lw10c", 1'b0, 3'b010, 32'h10, 32'h0);

    // Back-to-back: a load is held on the request port during a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 32'h10;
    req_wdata = 32'hA5; st_data = 32'hA5;
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 3'b010; req_addr = 32'h10; req_wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("b2b:held_not_ready", 32'(req_ready), 32'd0);
    end while (!rsp_valid && n < 6);
    check("b2b:first_latency", 32'(n), 32'd2);
    model[4] = merge(model[4], 2'd0, 3'b000, 32'hA5);
    @(negedge clk);
    check("b2b:ready_next_cycle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b:second_accepted", 32'(busy), 32'd1);
    wait_rsp(n);
    check("b2b:second_latency", 32'(n), 32'd2);
    check("b2b:rd_word", rd_word, model[4]);
    last_rd = model[4];
    @(negedge clk);

    // Reset during the merge cycle of a halfword store
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'b001; req_addr = 32'h12;
    req_wdata = 32'h1234; st_data = 32'h1234;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstm:read_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("rstm:in_merge", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstm:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstm:busy", 32'(busy), 32'd0);
    check("rstm:req_ready", 32'(req_ready), 32'd1);
    check("rstm:rd_word", rd_word, 32'd0);
    check("rstm:offset", 32'(offset), 32'd0);
    check("rstm:size_q", 32'(size_q), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    last_rd = '0;
    access("rstm_lw", 1'b0, 3'b010, 32'h10, 32'h0);

    // Address wrap modulo RAM size
    access("sw1010", 1'b1, 3'b010, 32'h1010, 32'hCAFEF00D);
    access("lw_wrap", 1'b0, 3'b010, 32'h10, 32'h0);

    // Randomized accesses over a pool of initialised words
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 1023));
      a = ($urandom_range(0, 15) << 12) | (32'(pool[i]) << 2);
      access("rnd_init", 1'b1, 3'b010, a, $urandom);
    end
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 15) << 12) | (32'(pool[$urandom_range(0, 7)]) << 2)
          | $urandom_range(0, 3);
      access("rnd", 1'($urandom), 3'($urandom), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
